// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a request/grant/response memory port
// and an FQ_DEPTH-entry prefetch queue presenting {pc, inst} to decode via valid/ready.
//
// Build option: define IF_COMPRESSED_EN to enable RVC (+2 step for 16-bit encodings,
// misaligned only when pc[0]=1). Without it every step is +4, inst_compr_o is tied 0
// and any pc[1:0]!=0 is misaligned.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   redirect_valid_i/   branch/jump redirect and its target (highest priority:
//   redirect_pc_i       flushes the queue and kills any in-flight fetch)
//   imem_req_o/addr_o   fetch request and address (address stable while stalled)
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/      fetch response and data (at least one cycle after grant)
//   imem_rdata_i
//   inst_valid_o/       queue head handshake towards decode
//   inst_ready_i
//   inst_out_o/pc_o     head instruction (NOP when empty) and its PC (0 when empty)
//   inst_compr_o        head is a 16-bit encoding
//   misaligned_pc_o     head carries a misaligned-PC fault
module if_fetch_queue #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_out_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_compr_o,
  output logic            misaligned_pc_o
);

  localparam int unsigned     PtrW    = $clog2(FQ_DEPTH);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(FQ_DEPTH);
  localparam logic [XLEN-1:0] Nop     = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halt_q, halt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic [XLEN-1:0] pc_mem_q    [FQ_DEPTH];
  logic [XLEN-1:0] inst_mem_q  [FQ_DEPTH];
  logic            fault_mem_q [FQ_DEPTH];

  logic            push, pop, push_fault, misaligned;
  logic [XLEN-1:0] push_inst, pc_incr;

`ifdef IF_COMPRESSED_EN
  assign misaligned = pc_q[0];
  assign pc_incr    = (imem_rdata_i[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
`else
  assign misaligned = |pc_q[1:0];
  assign pc_incr    = XLEN'(4);
`endif

  assign imem_addr_o = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    halt_d     = halt_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    push_inst  = imem_rdata_i;
    push_fault = 1'b0;

    case (state_q)
      StIdle: begin
        if (!halt_q && (count_q < FullCnt)) state_d = StReq;
      end
      StReq: begin
        // A misaligned pc never reaches the memory port; it becomes a fault entry.
        if (misaligned) begin
          if (count_q < FullCnt) begin
            push       = 1'b1;
            push_inst  = Nop;
            push_fault = 1'b1;
            halt_d     = 1'b1;
            state_d    = StIdle;
          end
        end else begin
          imem_req_o = 1'b1;
          if (imem_gnt_i) state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          push    = 1'b1;
          pc_d    = pc_q + pc_incr;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid_i) begin
      pc_d   = redirect_pc_i;
      halt_d = 1'b0;
      push   = 1'b0;
      case (state_q)
        StReq:  state_d = (imem_req_o && imem_gnt_i) ? StDrop : StReq;
        // A response arriving with the redirect is dropped on the spot; otherwise
        // it is still owed and must be swallowed in StDrop.
        StWait, StDrop: state_d = imem_rvalid_i ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end
  end

  // Redirect flushes the queue and overrides any same-cycle pop.
  assign pop = inst_valid_o && inst_ready_i && !redirect_valid_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      halt_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halt_q   <= halt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is gated by inst_valid_o.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      inst_mem_q[wr_ptr_q]  <= push_inst;
      fault_mem_q[wr_ptr_q] <= push_fault;
    end
  end

  assign inst_valid_o = (count_q != '0);

  always_comb begin
    inst_out_o      = Nop;
    inst_pc_o       = '0;
    inst_compr_o    = 1'b0;
    misaligned_pc_o = 1'b0;
    if (inst_valid_o) begin
      inst_out_o      = inst_mem_q[rd_ptr_q];
      inst_pc_o       = pc_mem_q[rd_ptr_q];
      misaligned_pc_o = fault_mem_q[rd_ptr_q];
`ifdef IF_COMPRESSED_EN
      inst_compr_o    = (inst_mem_q[rd_ptr_q][1:0] != 2'b11);
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a randomised memory responder plus a fetch-stream model.
// The model knows only the architectural rules: starting from the last redirect (or
// RESET_PC) decode must see mem(pc) in program order, pc stepping by the encoding
// size, and a misaligned pc yields one NOP fault entry after which fetch halts.
module tb_if_fetch_queue;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk, rst_n;
  logic            redirect_valid, imem_req, imem_gnt, imem_rvalid;
  logic            inst_valid, inst_ready, inst_compr, misaligned_pc;
  logic [XLEN-1:0] redirect_pc, imem_addr, imem_rdata, inst_out, inst_pc;

  if_fetch_queue #(
    .XLEN    (XLEN),
    .FQ_DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (imem_gnt),
    .imem_rvalid_i   (imem_rvalid),
    .imem_rdata_i    (imem_rdata),
    .inst_valid_o    (inst_valid),
    .inst_ready_i    (inst_ready),
    .inst_out_o      (inst_out),
    .inst_pc_o       (inst_pc),
    .inst_compr_o    (inst_compr),
    .misaligned_pc_o (misaligned_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Responder state
  bit          pending = 0, pend_killed = 0;
  int          wait_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          gnt_pct = 100, ready_pct = 100, lat_max = 0, force_lat = 0;
  int          live_resp = 0;

  // Stream model
  logic [31:0] exp_pc = 32'h0;
  bit          halted = 0;
  int          pops = 0;
  logic [31:0] pop_pc[$], pop_inst[$], pop_cmp[$], pop_mis[$], gnt_addr[$];

  bit          prev_stall = 0, prev_redir = 0;
  logic [31:0] prev_addr = '0;
  bit          last_gnt, last_req, last_valid;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h00A0_0113;
      32'h8: return 32'h0020_81B3;
`ifdef IF_COMPRESSED_EN
      32'h20: return 32'h0000_4501;
`endif
      default: begin
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_C0DE;
`ifdef IF_COMPRESSED_EN
        if (h[9]) return {16'h0, h[15:2], 2'b01};
`endif
        return {h[31:2], 2'b11};
      end
    endcase
  endfunction

  function automatic bit is_compr(input logic [31:0] i);
`ifdef IF_COMPRESSED_EN
    return i[1:0] != 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_misal(input logic [31:0] a);
`ifdef IF_COMPRESSED_EN
    return a[0];
`else
    return a[1:0] != 2'b00;
`endif
  endfunction

  // One clock: sample at the falling edge, check, then drive the next inputs.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    bit          rv, g, rdy, ef;
    logic [31:0] rd, epc, einst;
    @(negedge clk);
    if (!inst_valid) begin
      chk("empty_inst", inst_out, NOP);
      chk("empty_pc", inst_pc, 32'h0);
      chk("empty_compr", inst_compr, 32'h0);
      chk("empty_fault", misaligned_pc, 32'h0);
    end
    if (pending) chk("one_outstanding", imem_req, 32'h0);
    if (prev_stall && !prev_redir) begin
      chk("req_hold", imem_req, 32'h1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    if (halted) begin
      chk("halt_req", imem_req, 32'h0);
      chk("halt_valid", inst_valid, 32'h0);
    end
    rv = 0;
    rd = $urandom;
    if (pending) begin
      if (wait_cnt == 0) begin
        rv = 1;
        rd = mem_fn(pend_addr);
      end else wait_cnt--;
    end
    g   = imem_req && !pending && (int'($urandom_range(99)) < gnt_pct);
    rdy = int'($urandom_range(99)) < ready_pct;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    imem_gnt       = g;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rv) begin
      if (!pend_killed && !redir) live_resp++;
      pending = 0;
    end
    if (pending && redir) pend_killed = 1;
    if (redir) begin
      exp_pc = rpc;
      halted = 0;
      gnt_addr.delete();
    end
    if (g) begin
      pending     = 1;
      pend_addr   = imem_addr;
      pend_killed = redir;
      wait_cnt    = (force_lat >= 0) ? force_lat : int'($urandom_range(lat_max));
      if (!redir) gnt_addr.push_back(imem_addr);
    end
    last_gnt = g; last_req = imem_req; last_addr = imem_addr; last_valid = inst_valid;
    if (!redir && inst_valid && rdy && !halted) begin
      epc   = exp_pc;
      ef    = is_misal(epc);
      einst = ef ? NOP : mem_fn(epc);
      chk("pop_pc", inst_pc, epc);
      chk("pop_inst", inst_out, einst);
      chk("pop_compr", inst_compr, 32'(is_compr(einst)));
      chk("pop_fault", misaligned_pc, 32'(ef));
      pop_pc.push_back(inst_pc); pop_inst.push_back(inst_out);
      pop_cmp.push_back(32'(inst_compr)); pop_mis.push_back(32'(misaligned_pc));
      pops++;
      if (ef) halted = 1;
      else exp_pc = exp_pc + (is_compr(einst) ? 32'd2 : 32'd4);
    end
    prev_stall = imem_req && !g;
    prev_addr  = imem_addr;
    prev_redir = redir;
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_req"}, imem_req, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, inst_valid, 32'h0);
    chk({tag, "_inst"}, inst_out, NOP);
    chk({tag, "_pc"}, inst_pc, 32'h0);
    chk({tag, "_compr"}, inst_compr, 32'h0);
    chk({tag, "_fault"}, misaligned_pc, 32'h0);
  endtask

  initial begin
    int p0;
    bit seen;
    logic [31:0] tgt;
    rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
    repeat (2) @(negedge clk);
    reset_outputs_chk("reset");
    rst_n = 1;

    // In-order delivery of the first three instructions, 1-cycle memory latency.
    for (int i = 0; i < 100 && pops < 3; i++) tick(0, '0);
    chk("basic_count", 32'(pops >= 3), 32'h1);
    if (pops >= 3) begin
      chk("basic_pc0", pop_pc[0], 32'h0);  chk("basic_in0", pop_inst[0], 32'h0050_0093);
      chk("basic_pc1", pop_pc[1], 32'h4);  chk("basic_in1", pop_inst[1], 32'h00A0_0113);
      chk("basic_pc2", pop_pc[2], 32'h8);  chk("basic_in2", pop_inst[2], 32'h0020_81B3);
    end

    // Decode stalled: exactly FQ_DEPTH entries fetched, then the port goes quiet.
    ready_pct = 0;
    live_resp = 0;
    tick(1, 32'h200);
    repeat (40) tick(0, '0);
    chk("full_pushes", live_resp, 32'd4);
    for (int i = 0; i < 8; i++) begin
      tick(0, '0);
      chk("full_noreq", last_req, 32'h0);
      chk("full_valid", last_valid, 32'h1);
    end
    ready_pct = 100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(0, '0); seen = last_gnt; end
    chk("resume_fetch", 32'(seen), 32'h1);

    // Redirect while waiting; the stale response arrives two cycles after it.
    force_lat = 2;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(0, '0); seen = last_gnt; end
    force_lat = 0;
    tick(1, 32'h100);
    tick(0, '0);
    chk("wait_redir_flush", last_valid, 32'h0);
    seen = last_req;
    for (int i = 0; i < 20 && !seen; i++) begin tick(0, '0); seen = last_req; end
    chk("wait_redir_seen", 32'(seen), 32'h1);
    chk("wait_redir_addr", last_addr, 32'h100);

    // Redirect coincident with the response.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(0, '0); seen = last_gnt; end
    tick(1, 32'h300);
    tick(0, '0);
    chk("rv_redir_req", last_req, 32'h1);
    chk("rv_redir_addr", last_addr, 32'h300);

`ifdef IF_COMPRESSED_EN
    tick(1, 32'h20);
    p0 = pops;
    for (int i = 0; i < 40 && gnt_addr.size() < 2; i++) tick(0, '0);
    chk("rvc_pop_seen", 32'(pops > p0), 32'h1);
    if (pops > p0) begin
      chk("rvc_pc", pop_pc[p0], 32'h20);
      chk("rvc_inst", pop_inst[p0], 32'h4501);
      chk("rvc_compr", pop_cmp[p0], 32'h1);
    end
    chk("rvc_next_addr", (gnt_addr.size() >= 2) ? gnt_addr[1] : 32'hFFFF_FFFF, 32'h22);
`endif

    // Misaligned target: one fault entry, then no fetch until redirected.
    tick(1, 32'h31);
    for (int i = 0; i < 40 && !halted; i++) tick(0, '0);
    chk("mis_halted", 32'(halted), 32'h1);
    if (pops > 0) begin
      chk("mis_pc", pop_pc[pops-1], 32'h31);
      chk("mis_inst", pop_inst[pops-1], NOP);
      chk("mis_flag", pop_mis[pops-1], 32'h1);
    end
    for (int i = 0; i < 10; i++) begin tick(0, '0); chk("mis_noreq", last_req, 32'h0); end
    tick(1, 32'h40);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(0, '0); seen = last_req; end
    chk("mis_resume", 32'(seen), 32'h1);
    chk("mis_resume_addr", last_addr, 32'h40);

    // Random traffic with occasional (sometimes misaligned) redirects.
    gnt_pct = 70; ready_pct = 60; lat_max = 3; force_lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 4) begin
        tgt = {22'h0, 8'($urandom_range(255)), 2'b00};
        if ($urandom_range(9) == 0) tgt = tgt + 32'($urandom_range(1, 3));
        tick(1, tgt);
      end else tick(0, '0);
    end
    chk("random_pops", 32'(pops > 100), 32'h1);

    // Asynchronous reset in the middle of a wait.
    gnt_pct = 100; ready_pct = 100; force_lat = 4;
    tick(1, 32'h80);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(0, '0); seen = last_gnt; end
    tick(0, '0);
    #2 rst_n = 0;
    #1 reset_outputs_chk("midwait");
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0;
    pending = 0; exp_pc = 32'h0; halted = 0; prev_stall = 0; prev_redir = 0;
    force_lat = 0;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(0, '0); seen = last_req; end
    chk("post_reset_req", 32'(seen), 32'h1);
    chk("post_reset_addr", last_addr, 32'h0);
    repeat (30) tick(0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
